// File: rtl/bmp_stream_pkg.sv
// Shared types and defaults for the slave-port frame streamer.
//  - stream_state_e : frame sequencing states
//  - MODE_*         : processing-mode encodings carried on slv_mode. The
//                     streamer does not interpret them.
//  - DEF_*          : default widths/depth used by the streamer
package bmp_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } stream_state_e;

  localparam logic [1:0] MODE_0 = 2'd0;
  localparam logic [1:0] MODE_1 = 2'd1;
  localparam logic [1:0] MODE_2 = 2'd2;
  localparam logic [1:0] MODE_3 = 2'd3;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_COLOR_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH  = 16;
  localparam int DEF_CNT_WIDTH   = 16;
  localparam int DEF_FIFO_DEPTH  = 4;

endpackage

// File: rtl/bmp_sync_fifo.sv
// Small synchronous FIFO that buffers prefetched pixel words.
// Ports:
//  clk, rst_n  clock, asynchronous active-low reset
//  push        write push_data (ignored when full unless popping in the same cycle)
//  push_data   word to store
//  pop         remove the head word (ignored when empty)
//  pop_data    head word. It reads 0 while the FIFO is empty.
//  full/empty  occupancy flags
//  count       number of stored words, 0..DEPTH
// A push and a pop in the same cycle leave the occupancy unchanged. This also
// holds when the FIFO is full, because the pop frees the slot that is written.
module bmp_sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [DATA_WIDTH-1:0]     push_data,
  input  logic                      pop,
  output logic [DATA_WIDTH-1:0]     pop_data,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        cnt;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign count   = cnt;
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Storage needs no reset. Nothing is read while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (PTR_W+1)'(1);
        2'b01:   cnt <= cnt - (PTR_W+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/bmp_slave_streamer.sv
// Frame transmitter for one accelerator slave port. On an accepted start it
// latches the frame configuration. It then reads cfg_num_words words from
// base address upward out of a memory with 1-cycle read latency, and streams
// the words in order on the slv_* interface.
// Ports:
//  clk, rst_n          clock, asynchronous active-low reset
//  start, cfg_*        frame request and configuration, sampled only in IDLE
//  mem_rd_en/mem_addr  read strobe and word address (base + issued, wrapping)
//  mem_rd_data         read data, valid the cycle after mem_rd_en
//  slv_mode/proc_val   latched frame configuration, stable for the frame
//  slv_data/valid/rdy  word stream toward the accelerator
//  busy                high whenever the sequencer is not idle
//  done                one-cycle pulse when the last word has been taken
// Handshake: slv_data_valid is high exactly while a buffered word exists.
// A word is transferred on a rising edge where slv_data_valid and slv_rdy
// are both high. While slv_data_valid is high and slv_rdy is low, slv_data
// does not change.
module bmp_slave_streamer
  import bmp_stream_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int COLOR_WIDTH = DEF_COLOR_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [1:0]             cfg_mode,
  input  logic [COLOR_WIDTH-1:0] cfg_proc_val,
  input  logic [ADDR_WIDTH-1:0]  cfg_base_addr,
  input  logic [CNT_WIDTH-1:0]   cfg_num_words,
  output logic                   mem_rd_en,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [DATA_WIDTH-1:0]  mem_rd_data,
  output logic [1:0]             slv_mode,
  output logic [COLOR_WIDTH-1:0] slv_proc_val,
  output logic [DATA_WIDTH-1:0]  slv_data,
  output logic                   slv_data_valid,
  input  logic                   slv_rdy,
  output logic                   busy,
  output logic                   done
);

  localparam int FC_W = $clog2(FIFO_DEPTH) + 1;

  stream_state_e          state;
  stream_state_e          state_nxt;
  logic [1:0]             mode_q;
  logic [COLOR_WIDTH-1:0] proc_val_q;
  logic [ADDR_WIDTH-1:0]  base_q;
  logic [CNT_WIDTH-1:0]   num_q;
  logic [CNT_WIDTH-1:0]   issued;
  logic [CNT_WIDTH-1:0]   sent;
  logic [CNT_WIDTH-1:0]   issued_inc;
  logic [CNT_WIDTH-1:0]   sent_inc;
  logic                   inflight;
  logic                   start_ok;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [FC_W-1:0]        fifo_cnt;
  logic [FC_W:0]          credit_used;
  logic [FC_W:0]          credit_lim;
  logic                   unused_full;

  assign start_ok = (state == IDLE) & start;
  assign fifo_pop = ~fifo_empty & slv_rdy;

  // A read is issued only when it has a FIFO slot. Words already buffered or
  // still in flight occupy slots, and a word leaving this cycle frees one.
  // The FIFO therefore cannot overflow, so its full flag is not needed here.
  assign credit_used = {1'b0, fifo_cnt} + {{FC_W{1'b0}}, inflight};
  assign credit_lim  = (FC_W+1)'(FIFO_DEPTH) + {{FC_W{1'b0}}, fifo_pop};
  assign mem_rd_en   = (state == STREAM) & (issued != num_q) &
                       (credit_used < credit_lim);
  assign mem_addr    = base_q + ADDR_WIDTH'(issued);

  assign issued_inc = issued + {{(CNT_WIDTH-1){1'b0}}, mem_rd_en};
  assign sent_inc   = sent + {{(CNT_WIDTH-1){1'b0}}, fifo_pop};

  assign slv_mode       = mode_q;
  assign slv_proc_val   = proc_val_q;
  assign slv_data_valid = ~fifo_empty;
  assign busy           = (state != IDLE);
  assign done           = (state == DONE);
  assign unused_full    = fifo_full;

  // The next state looks at the post-increment counters. This lets DONE
  // follow the cycle of the last transfer directly.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (cfg_num_words == '0) ? DONE : STREAM;
      STREAM:  if (issued_inc == num_q) state_nxt = DRAIN;
      DRAIN:   if (sent_inc == num_q) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mode_q     <= '0;
      proc_val_q <= '0;
      base_q     <= '0;
      num_q      <= '0;
      issued     <= '0;
      sent       <= '0;
      inflight   <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= mem_rd_en;
      if (start_ok) begin
        mode_q     <= cfg_mode;
        proc_val_q <= cfg_proc_val;
        base_q     <= cfg_base_addr;
        num_q      <= cfg_num_words;
        issued     <= '0;
        sent       <= '0;
      end else begin
        issued <= issued_inc;
        sent   <= sent_inc;
      end
    end
  end

  // Read data is pushed on the edge that ends the cycle after its strobe.
  bmp_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (mem_rd_data),
    .pop       (fifo_pop),
    .pop_data  (slv_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

endmodule
